// File: rtl/sram_oq_scheduler.sv
// Output-queue SRAM command sequencer: owns per-queue circular pointers/counts and arbitrates writes vs round-robin reads.
// Command registered 1 cycle after issue; a held command (cmd_ready=0) blocks new issue, bad-qid writes are dropped regardless.
module sram_oq_scheduler #(
  parameter int NUM_QUEUES     = 5,
  parameter int QUEUE_ID_WIDTH = 3,
  parameter int MEM_ADDR_WIDTH = 19,
  parameter int QUEUE_SIZE     = 104857
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      wr_valid,
  input  logic [QUEUE_ID_WIDTH-1:0] wr_qid,
  output logic                      wr_ready,
  input  logic [NUM_QUEUES-1:0]     rd_en,
  output logic [NUM_QUEUES-1:0]     rd_grant,
  output logic                      cmd_valid,
  output logic                      cmd_write,
  output logic [MEM_ADDR_WIDTH-1:0] cmd_addr,
  output logic [QUEUE_ID_WIDTH-1:0] cmd_qid,
  input  logic                      cmd_ready,
  output logic [NUM_QUEUES-1:0]     q_empty,
  output logic [NUM_QUEUES-1:0]     q_full,
  output logic                      err_bad_qid
);

  localparam int PTR_W = (QUEUE_SIZE > 1) ? $clog2(QUEUE_SIZE) : 1;
  localparam int CNT_W = $clog2(QUEUE_SIZE + 1);
  localparam logic [PTR_W-1:0]          PTR_LAST = PTR_W'(QUEUE_SIZE - 1);
  localparam logic [CNT_W-1:0]          CNT_FULL = CNT_W'(QUEUE_SIZE);
  localparam logic [QUEUE_ID_WIDTH:0]   NQ       = (QUEUE_ID_WIDTH + 1)'(NUM_QUEUES);
  localparam logic [QUEUE_ID_WIDTH-1:0] QID_LAST = QUEUE_ID_WIDTH'(NUM_QUEUES - 1);

  if (longint'(NUM_QUEUES) * longint'(QUEUE_SIZE) > (longint'(1) << MEM_ADDR_WIDTH)) begin : g_bad_cfg
    $error("sram_oq_scheduler: NUM_QUEUES*QUEUE_SIZE exceeds SRAM address space");
  end

  logic [PTR_W-1:0] wr_ptr_q [NUM_QUEUES];
  logic [PTR_W-1:0] wr_ptr_d [NUM_QUEUES];
  logic [PTR_W-1:0] rd_ptr_q [NUM_QUEUES];
  logic [PTR_W-1:0] rd_ptr_d [NUM_QUEUES];
  logic [CNT_W-1:0] cnt_q    [NUM_QUEUES];
  logic [CNT_W-1:0] cnt_d    [NUM_QUEUES];

  logic [QUEUE_ID_WIDTH-1:0] rr_last_q, rr_last_d;
  logic                      last_was_write_q, last_was_write_d;
  logic                      cmd_valid_q, cmd_valid_d;
  logic                      cmd_write_q, cmd_write_d;
  logic [MEM_ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [QUEUE_ID_WIDTH-1:0] cmd_qid_q, cmd_qid_d;
  logic [NUM_QUEUES-1:0]     q_empty_q, q_empty_d;
  logic [NUM_QUEUES-1:0]     q_full_q, q_full_d;
  logic                      err_bad_qid_q, err_bad_qid_d;

  logic                      load, bad_qid, wr_full, wr_elig, rd_found, do_wr, do_rd;
  logic [NUM_QUEUES-1:0]     rd_elig;
  logic [QUEUE_ID_WIDTH-1:0] cand, rd_sel;

  always_comb begin
    load     = ~cmd_valid_q | cmd_ready;
    bad_qid  = wr_valid & ({1'b0, wr_qid} >= NQ);
    wr_full  = 1'b0;
    rd_elig  = '0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      if (wr_qid == QUEUE_ID_WIDTH'(i)) wr_full = (cnt_q[i] == CNT_FULL);
      rd_elig[i] = rd_en[i] & (cnt_q[i] != '0);
    end
    wr_elig = wr_valid & ~bad_qid & ~wr_full;

    // Round-robin scan starts one past the last granted queue.
    cand     = rr_last_q;
    rd_found = 1'b0;
    rd_sel   = '0;
    for (int k = 0; k < NUM_QUEUES; k++) begin
      cand = (cand == QID_LAST) ? '0 : cand + 1'b1;
      for (int i = 0; i < NUM_QUEUES; i++) begin
        if (!rd_found && (cand == QUEUE_ID_WIDTH'(i)) && rd_elig[i]) begin
          rd_found = 1'b1;
          rd_sel   = cand;
        end
      end
    end

    do_wr    = load & wr_elig & (~rd_found | ~last_was_write_q);
    do_rd    = load & rd_found & ~do_wr;
    wr_ready = do_wr | bad_qid;

    rd_grant         = '0;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    cnt_d            = cnt_q;
    rr_last_d        = do_rd ? rd_sel : rr_last_q;
    last_was_write_d = do_wr ? 1'b1 : (do_rd ? 1'b0 : last_was_write_q);
    cmd_valid_d      = load ? (do_wr | do_rd) : cmd_valid_q;
    cmd_write_d      = cmd_write_q;
    cmd_addr_d       = cmd_addr_q;
    cmd_qid_d        = cmd_qid_q;
    err_bad_qid_d    = bad_qid;

    for (int i = 0; i < NUM_QUEUES; i++) begin
      if (do_wr && (wr_qid == QUEUE_ID_WIDTH'(i))) begin
        wr_ptr_d[i] = (wr_ptr_q[i] == PTR_LAST) ? '0 : wr_ptr_q[i] + PTR_W'(1);
        cnt_d[i]    = cnt_q[i] + CNT_W'(1);
        cmd_write_d = 1'b1;
        cmd_addr_d  = MEM_ADDR_WIDTH'(i * QUEUE_SIZE) + MEM_ADDR_WIDTH'(wr_ptr_q[i]);
        cmd_qid_d   = QUEUE_ID_WIDTH'(i);
      end
      if (do_rd && (rd_sel == QUEUE_ID_WIDTH'(i))) begin
        rd_grant[i] = 1'b1;
        rd_ptr_d[i] = (rd_ptr_q[i] == PTR_LAST) ? '0 : rd_ptr_q[i] + PTR_W'(1);
        cnt_d[i]    = cnt_q[i] - CNT_W'(1);
        cmd_write_d = 1'b0;
        cmd_addr_d  = MEM_ADDR_WIDTH'(i * QUEUE_SIZE) + MEM_ADDR_WIDTH'(rd_ptr_q[i]);
        cmd_qid_d   = QUEUE_ID_WIDTH'(i);
      end
    end

    for (int i = 0; i < NUM_QUEUES; i++) begin
      q_empty_d[i] = (cnt_d[i] == '0);
      q_full_d[i]  = (cnt_d[i] == CNT_FULL);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_QUEUES; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      rr_last_q        <= QID_LAST;
      last_was_write_q <= 1'b0;
      cmd_valid_q      <= 1'b0;
      cmd_write_q      <= 1'b0;
      cmd_addr_q       <= '0;
      cmd_qid_q        <= '0;
      q_empty_q        <= '1;
      q_full_q         <= '0;
      err_bad_qid_q    <= 1'b0;
    end else begin
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      cnt_q            <= cnt_d;
      rr_last_q        <= rr_last_d;
      last_was_write_q <= last_was_write_d;
      cmd_valid_q      <= cmd_valid_d;
      cmd_write_q      <= cmd_write_d;
      cmd_addr_q       <= cmd_addr_d;
      cmd_qid_q        <= cmd_qid_d;
      q_empty_q        <= q_empty_d;
      q_full_q         <= q_full_d;
      err_bad_qid_q    <= err_bad_qid_d;
    end
  end

  assign cmd_valid   = cmd_valid_q;
  assign cmd_write   = cmd_write_q;
  assign cmd_addr    = cmd_addr_q;
  assign cmd_qid     = cmd_qid_q;
  assign q_empty     = q_empty_q;
  assign q_full      = q_full_q;
  assign err_bad_qid = err_bad_qid_q;

endmodule

// File: tb/tb_sram_oq_scheduler.sv
// Scoreboard bench: directed cycles push expected SRAM commands; a monitor pops on every accepted command.
module tb_sram_oq_scheduler;

  localparam int NQ = 5;
  localparam int QW = 3;
  localparam int AW = 19;
  localparam int QS = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          wr_valid = 1'b0;
  logic [QW-1:0] wr_qid = '0;
  logic          wr_ready;
  logic [NQ-1:0] rd_en = '0;
  logic [NQ-1:0] rd_grant;
  logic          cmd_valid, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [QW-1:0] cmd_qid;
  logic          cmd_ready = 1'b0;
  logic [NQ-1:0] q_empty, q_full;
  logic          err_bad_qid;

  typedef struct packed {
    logic          w;
    logic [AW-1:0] addr;
    logic [QW-1:0] qid;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sram_oq_scheduler #(
    .NUM_QUEUES(NQ), .QUEUE_ID_WIDTH(QW), .MEM_ADDR_WIDTH(AW), .QUEUE_SIZE(QS)
  ) dut (
    .clk(clk), .resetn(resetn),
    .wr_valid(wr_valid), .wr_qid(wr_qid), .wr_ready(wr_ready),
    .rd_en(rd_en), .rd_grant(rd_grant),
    .cmd_valid(cmd_valid), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_qid(cmd_qid), .cmd_ready(cmd_ready),
    .q_empty(q_empty), .q_full(q_full), .err_bad_qid(err_bad_qid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted command must match the oldest expected entry.
  always @(negedge clk) begin
    if (resetn && cmd_valid && cmd_ready) begin
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL cmd_unexpected: got w=%0d addr=%0d qid=%0d expected none", cmd_write, cmd_addr, cmd_qid);
      end else begin
        e = exp_q.pop_front();
        if (cmd_write !== e.w || cmd_addr !== e.addr || cmd_qid !== e.qid) begin
          errors++;
          $display("FAIL cmd: got w=%0d addr=%0d qid=%0d expected w=%0d addr=%0d qid=%0d",
                   cmd_write, cmd_addr, cmd_qid, e.w, e.addr, e.qid);
        end
      end
    end
  end

  // One cycle: drive at posedge+1, check combinational outputs at negedge, push expected command.
  task automatic cyc(input logic wv, input logic [QW-1:0] qid, input logic [NQ-1:0] rden,
                     input logic crdy, input logic e_wrdy, input logic [NQ-1:0] e_gnt,
                     input logic push, input logic ew, input int ea, input logic [QW-1:0] eq);
    exp_t e;
    wr_valid  = wv;
    wr_qid    = qid;
    rd_en     = rden;
    cmd_ready = crdy;
    @(negedge clk);
    chk("wr_ready", 32'(wr_ready), 32'(e_wrdy));
    chk("rd_grant", 32'(rd_grant), 32'(e_gnt));
    if (push) begin
      e.w = ew; e.addr = AW'(ea); e.qid = eq;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0, 0, '0);
  endtask

  task automatic do_reset();
    wr_valid = 1'b0; rd_en = '0; cmd_ready = 1'b0;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    do_reset();
    chk("rst_cmd_valid", 32'(cmd_valid), 0);
    chk("rst_cmd_write", 32'(cmd_write), 0);
    chk("rst_cmd_addr", 32'(cmd_addr), 0);
    chk("rst_cmd_qid", 32'(cmd_qid), 0);
    chk("rst_q_empty", 32'(q_empty), 32'h1f);
    chk("rst_q_full", 32'(q_full), 0);
    chk("rst_err", 32'(err_bad_qid), 0);

    // Three writes to q2: base 2*QS = 8
    for (int k = 0; k < 3; k++) cyc(1'b1, 3'd2, '0, 1'b1, 1'b1, '0, 1'b1, 1'b1, 8 + k, 3'd2);
    chk("q_empty_after_q2", 32'(q_empty), 32'h1b);
    idle(2);

    // Fill q0, hold fifth write, drain, then wrap
    do_reset();
    for (int k = 0; k < 4; k++) cyc(1'b1, 3'd0, '0, 1'b1, 1'b1, '0, 1'b1, 1'b1, k, 3'd0);
    chk("q_full_q0", 32'(q_full), 32'h01);
    cyc(1'b1, 3'd0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0, 0, '0);
    cyc(1'b1, 3'd0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0, 0, '0);
    for (int k = 0; k < 4; k++) cyc(1'b0, 3'd0, 5'b00001, 1'b1, 1'b0, 5'b00001, 1'b1, 1'b0, k, 3'd0);
    chk("q_empty_drained", 32'(q_empty), 32'h1f);
    chk("q_full_drained", 32'(q_full), 0);
    cyc(1'b0, 3'd0, 5'b00001, 1'b1, 1'b0, '0, 1'b0, 1'b0, 0, '0);
    cyc(1'b1, 3'd0, '0, 1'b1, 1'b1, '0, 1'b1, 1'b1, 0, 3'd0);
    idle(2);

    // Round-robin reads over q0, q1, q3
    do_reset();
    for (int k = 0; k < 2; k++) cyc(1'b1, 3'd0, '0, 1'b1, 1'b1, '0, 1'b1, 1'b1, 0 + k, 3'd0);
    for (int k = 0; k < 2; k++) cyc(1'b1, 3'd1, '0, 1'b1, 1'b1, '0, 1'b1, 1'b1, 4 + k, 3'd1);
    for (int k = 0; k < 2; k++) cyc(1'b1, 3'd3, '0, 1'b1, 1'b1, '0, 1'b1, 1'b1, 12 + k, 3'd3);
    for (int k = 0; k < 2; k++) begin
      cyc(1'b0, '0, 5'h1f, 1'b1, 1'b0, 5'b00001, 1'b1, 1'b0, 0 + k, 3'd0);
      cyc(1'b0, '0, 5'h1f, 1'b1, 1'b0, 5'b00010, 1'b1, 1'b0, 4 + k, 3'd1);
      cyc(1'b0, '0, 5'h1f, 1'b1, 1'b0, 5'b01000, 1'b1, 1'b0, 12 + k, 3'd3);
    end
    cyc(1'b0, '0, 5'h1f, 1'b1, 1'b0, '0, 1'b0, 1'b0, 0, '0);
    chk("q_empty_rr_done", 32'(q_empty), 32'h1f);
    idle(1);

    // Alternation: q1 holds 2 words, continuous writes to q4
    do_reset();
    cyc(1'b1, 3'd1, '0, 1'b1, 1'b1, '0, 1'b1, 1'b1, 4, 3'd1);
    cyc(1'b1, 3'd1, '0, 1'b1, 1'b1, '0, 1'b1, 1'b1, 5, 3'd1);
    cyc(1'b1, 3'd4, 5'b00010, 1'b1, 1'b0, 5'b00010, 1'b1, 1'b0, 4, 3'd1);
    cyc(1'b1, 3'd4, 5'b00010, 1'b1, 1'b1, '0, 1'b1, 1'b1, 16, 3'd4);
    cyc(1'b1, 3'd4, 5'b00010, 1'b1, 1'b0, 5'b00010, 1'b1, 1'b0, 5, 3'd1);
    cyc(1'b1, 3'd4, 5'b00010, 1'b1, 1'b1, '0, 1'b1, 1'b1, 17, 3'd4);
    idle(2);

    // Backpressure: held command stays stable, no issue until release
    do_reset();
    cyc(1'b1, 3'd0, 5'b00001, 1'b1, 1'b1, '0, 1'b1, 1'b1, 0, 3'd0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 3'd0, 5'b00001, 1'b0, 1'b0, '0, 1'b0, 1'b0, 0, '0);
      chk("hold_valid", 32'(cmd_valid), 1);
      chk("hold_write", 32'(cmd_write), 1);
      chk("hold_addr", 32'(cmd_addr), 0);
      chk("hold_qid", 32'(cmd_qid), 0);
    end
    cyc(1'b1, 3'd0, 5'b00001, 1'b1, 1'b0, 5'b00001, 1'b1, 1'b0, 0, 3'd0);
    chk("release_valid", 32'(cmd_valid), 1);
    cyc(1'b1, 3'd0, 5'b00001, 1'b1, 1'b1, '0, 1'b1, 1'b1, 1, 3'd0);
    idle(2);

    // Bad queue ids (6 and 5 == NUM_QUEUES) are accepted and dropped
    cyc(1'b1, 3'd6, '0, 1'b1, 1'b1, '0, 1'b0, 1'b0, 0, '0);
    chk("bad6_err", 32'(err_bad_qid), 1);
    chk("bad6_no_cmd", 32'(cmd_valid), 0);
    cyc(1'b1, 3'd5, '0, 1'b1, 1'b1, '0, 1'b0, 1'b0, 0, '0);
    chk("bad5_err", 32'(err_bad_qid), 1);
    idle(1);
    chk("bad_err_cleared", 32'(err_bad_qid), 0);
    chk("bad_no_cmd_after", 32'(cmd_valid), 0);

    // Reset in the middle of a write burst to q3
    cyc(1'b1, 3'd3, '0, 1'b1, 1'b1, '0, 1'b1, 1'b1, 12, 3'd3);
    cyc(1'b1, 3'd3, '0, 1'b1, 1'b1, '0, 1'b0, 1'b0, 0, '0);
    resetn = 1'b0;
    #1;
    chk("midrst_cmd_valid", 32'(cmd_valid), 0);
    chk("midrst_q_empty", 32'(q_empty), 32'h1f);
    wr_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    cyc(1'b1, 3'd3, '0, 1'b1, 1'b1, '0, 1'b1, 1'b1, 12, 3'd3);
    idle(2);

    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
